keypad_scan: RTL and testbench

//  4x4 matrix keypad scanner with debounce, clocked at 250 Hz.

---
 rtl/keypad_scan.sv | 228 ++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//  4x4 matrix keypad scanner with debounce. It runs on a 250 Hz scan clock.
//  Exactly one row is driven low at a time. The columns are sampled for that
//  row. A key is accepted after DEBOUNCE_CNT identical single-key samples and
//  released after DEBOUNCE_CNT idle samples. Ghost samples (two or more
//  columns low) are treated as idle.
//
//  Ports
//   IN_clk      in   1  scan clock (250 Hz)
//   IN_reset    in   1  asynchronous, active-low reset
//   IN_col      in   4  column sense, active-low, externally pulled up
//   OUT_row     out  4  row drive, active-low, exactly one bit low
//   OUT_value   out  4  code of the last accepted key, held until the next one
//   OUT_key     out  1  one-cycle strobe; OUT_value is valid in the same cycle
//   OUT_pressed out  1  high while an accepted key is held
//
//  Key codes (row r low, column c low; c = 0..3):
//   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
//
//  Build option
//   KEY_REPEAT_EN  When defined, a held key auto-repeats. The first repeat
//                  comes REPEAT_DELAY cycles after the accept. Later repeats
//                  come every REPEAT_PERIOD cycles. Code F never repeats. The
//                  REPEAT_* parameters exist only in that build.
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int DEBOUNCE_CNT  = 3     // 1..15
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 125,  // >= 2
   parameter int REPEAT_PERIOD = 25    // >= 2
`endif
) (
   input  logic       IN_clk,
   input  logic       IN_reset,
   input  logic [3:0] IN_col,
   output logic [3:0] OUT_row,
   output logic [3:0] OUT_value,
   output logic       OUT_key,
   output logic       OUT_pressed
);

   typedef enum logic [1:0] {
      SCAN = 2'd0,
      DEB  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] DEB_TGT = 4'(DEBOUNCE_CNT);

   state_t     state, state_nx;
   logic [1:0] row_idx, row_idx_nx;   // index of the row currently driven low
   logic [3:0] pattern, pattern_nx;   // column pattern latched at press entry
   logic [3:0] cnt, cnt_nx;           // debounce count in DEB, release count in HOLD
   logic [3:0] value, value_nx;
   logic       key, key_nx;

   logic       col_valid;
   logic [1:0] col_idx;
   logic [3:0] cnt_inc;
   logic       accept;

`ifdef KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);
   localparam logic [RW-1:0] DELAY_T  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] PERIOD_T = RW'(REPEAT_PERIOD);

   logic [RW-1:0] held, held_nx, held_inc;  // held cycles since the last strobe
   logic          repeating, repeating_nx;  // first repeat already issued

   assign held_inc = held + RW'(1);
`endif

   // Hex code for a key position in the matrix.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   // A valid sample has exactly one column low. Idle and ghost patterns both fall
   // through to "not valid".
   always_comb begin
      col_valid = 1'b1;
      col_idx   = 2'd0;
      case (IN_col)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_valid = 1'b0;
      endcase
   end

   // cnt is 0 whenever the FSM is in SCAN, so cnt_inc is 1 on the entry sample.
   // That lets DEBOUNCE_CNT = 1 accept on the entry sample itself.
   assign cnt_inc = cnt + 4'd1;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
      state_nx   = state;
      row_idx_nx = row_idx;
      pattern_nx = pattern;
      cnt_nx     = cnt;
      value_nx   = value;
      key_nx     = 1'b0;
      accept     = 1'b0;
`ifdef KEY_REPEAT_EN
      held_nx      = held;
      repeating_nx = repeating;
`endif

      unique case (state)
         SCAN: begin
            if (col_valid) begin
               state_nx   = DEB;
               pattern_nx = IN_col;
               cnt_nx     = cnt_inc;
               accept     = (cnt_inc >= DEB_TGT);
            end else begin
               row_idx_nx = row_idx + 2'd1;
            end
         end

         DEB: begin
            if (IN_col == pattern) begin
               cnt_nx = cnt_inc;
               accept = (cnt_inc >= DEB_TGT);
            end else begin
               // Bounce, a ghost, or a different key all restart the scan on the next row.
               state_nx   = SCAN;
               cnt_nx     = 4'd0;
               row_idx_nx = row_idx + 2'd1;
            end
         end

         HOLD: begin
            if (col_valid) begin
               // Any key still seen on this row holds the press and restarts the release count.
               cnt_nx = 4'd0;
`ifdef KEY_REPEAT_EN
               if (IN_col == pattern) begin
                  if (held_inc == (repeating ? PERIOD_T : DELAY_T)) begin
                     held_nx      = '0;
                     repeating_nx = 1'b1;
                     // The !key guard keeps two strobes out of adjacent cycles.
                     if (value != 4'hF && !key) key_nx = 1'b1;
                  end else begin
                     held_nx = held_inc;
                  end
               end else begin
                  held_nx      = '0;
                  repeating_nx = 1'b0;
               end
`endif
            end else begin
`ifdef KEY_REPEAT_EN
               held_nx      = '0;
               repeating_nx = 1'b0;
`endif
               if (cnt_inc >= DEB_TGT) begin
                  state_nx   = SCAN;
                  cnt_nx     = 4'd0;
                  row_idx_nx = row_idx + 2'd1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
         end

         default: begin
            state_nx = SCAN;
            cnt_nx   = 4'd0;
         end
      endcase

      if (accept) begin
         state_nx = HOLD;
         cnt_nx   = 4'd0;
         value_nx = key_code(row_idx, col_idx);
         key_nx   = 1'b1;
`ifdef KEY_REPEAT_EN
         held_nx      = '0;
         repeating_nx = 1'b0;
`endif
      end
   end

   always_ff @(posedge IN_clk or negedge IN_reset) begin
      if (!IN_reset) begin
         state   <= SCAN;
         row_idx <= 2'd0;
         pattern <= 4'hF;
         cnt     <= 4'd0;
         value   <= 4'd0;
         key     <= 1'b0;
`ifdef KEY_REPEAT_EN
         held      <= '0;
         repeating <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments, so every flop updates from pre-edge values.
         state   <= state_nx;
         row_idx <= row_idx_nx;
         pattern <= pattern_nx;
         cnt     <= cnt_nx;
         value   <= value_nx;
         key     <= key_nx;
`ifdef KEY_REPEAT_EN
         held      <= held_nx;
         repeating <= repeating_nx;
`endif
      end
   end

   assign OUT_row     = ~(4'b0001 << row_idx);
   assign OUT_value   = value;
   assign OUT_key     = key;
   assign OUT_pressed = (state == HOLD);

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//  Directed bench for keypad_scan with the default parameters. A behavioural
//  4x4 keypad turns the set of pressed keys into column levels for whichever row
//  the DUT is driving. An override input can force raw column values instead.
//  Inputs change 1 time unit after each rising edge. Outputs are checked at the
//  same point.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   logic        clk;
   logic        reset_n;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  value;
   logic        key;
   logic        pressed;

   logic [15:0] keys;       // bit r*4+c set = key at row r, column c held down
   logic        use_force;
   logic [3:0]  col_force;
   logic [3:0]  matrix_col;

   int checks = 0;
   int errors = 0;

   keypad_scan dut (
      .IN_clk      (clk),
      .IN_reset    (reset_n),
      .IN_col      (col),
      .OUT_row     (row),
      .OUT_value   (value),
      .OUT_key     (key),
      .OUT_pressed (pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pressed key shorts its column to the row line, so a column reads low when
   // any pressed key on that column sits on the row being driven low.
   always_comb begin
      matrix_col = 4'b1111;
      for (int r = 0; r < 4; r++)
         if (!row[r])
            for (int c = 0; c < 4; c++)
               if (keys[r*4+c]) matrix_col[c] = 1'b0;
   end

   assign col = use_force ? col_force : matrix_col;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         strobes;
      int         found;
      logic [3:0] exp_row;

      // ---------------- T1: reset with a key-like column pattern ----------------
      reset_n   = 1'b0;
      use_force = 1'b1;
      col_force = 4'b1011;
      keys      = 16'h0000;
      #1;
      chk("t1_reset_row",     row,     4'b1110);
      chk("t1_reset_key",     key,     1'b0);
      chk("t1_reset_value",   value,   4'h0);
      chk("t1_reset_pressed", pressed, 1'b0);
      tick();
      chk("t1_reset_row_edge", row, 4'b1110);
      chk("t1_reset_key_edge", key, 1'b0);
      reset_n   = 1'b1;
      use_force = 1'b0;
      tick(); chk("t1_rot1", row, 4'b1101);
      tick(); chk("t1_rot2", row, 4'b1011);
      tick(); chk("t1_rot3", row, 4'b0111);
      tick(); chk("t1_rot4", row, 4'b1110);

      // ---------------- T2: clean press of '4' (row1, col0) ----------------
      keys = 16'h0010;
      tick(); chk("t2_to_row1", row, 4'b1101);   // row0 sampled idle
      tick(); chk("t2_e0_key", key, 1'b0);       // first valid sample
      chk("t2_e0_row_frozen", row, 4'b1101);
      tick(); chk("t2_e1_key", key, 1'b0);
      tick(); chk("t2_e2_key", key, 1'b1);       // DEBOUNCE_CNT = 3
      chk("t2_e2_value",   value,   4'h4);
      chk("t2_e2_pressed", pressed, 1'b1);
      strobes = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (key) strobes++;
      end
      chk("t2_no_restrobe",   strobes, 0);
      chk("t2_hold_pressed",  pressed, 1'b1);
      keys = 16'h0000;
      tick(); chk("t2_rel1_pressed", pressed, 1'b1);
      tick(); chk("t2_rel2_pressed", pressed, 1'b1);
      tick(); chk("t2_rel3_pressed", pressed, 1'b0);
      chk("t2_rel_row",   row,   4'b1011);
      chk("t2_rel_value", value, 4'h4);

      // ---------------- T3: bounce on 'F' (row3, col2) ----------------
      keys = 16'h4000;
      tick(); chk("t3_to_row3", row, 4'b0111);
      tick(); tick();                            // two matching samples
      chk("t3_burst_key", key, 1'b0);
      keys = 16'h0000;
      tick();                                    // bounce gap
      chk("t3_bounce_row",     row,     4'b1110);
      chk("t3_bounce_pressed", pressed, 1'b0);
      chk("t3_bounce_value",   value,   4'h4);
      keys = 16'h4000;
      strobes = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("t3_key_c%0d", i), key, (i == 5) ? 1'b1 : 1'b0);
      end
      chk("t3_value",   value,   4'hF);
      chk("t3_pressed", pressed, 1'b1);
      keys = 16'h0000;
      tick(); tick(); tick();
      chk("t3_rel_pressed", pressed, 1'b0);
      chk("t3_rel_row",     row,     4'b1110);

      // ---------------- T4: ghost on row0 (cols 0 and 1) ----------------
      keys = 16'h0003;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_row = ~(4'b0001 << ((i + 1) % 4));
         chk($sformatf("t4_row_c%0d", i),     row,     exp_row);
         chk($sformatf("t4_key_c%0d", i),     key,     1'b0);
         chk($sformatf("t4_pressed_c%0d", i), pressed, 1'b0);
      end
      chk("t4_value_kept", value, 4'hF);

      // Ghost while holding counts as release.
      keys = 16'h0001;
      tick(); tick(); tick();
      chk("t4b_key",   key,   1'b1);
      chk("t4b_value", value, 4'h1);
      keys = 16'h0003;
      tick(); chk("t4b_g1_pressed", pressed, 1'b1);
      chk("t4b_g1_key", key, 1'b0);
      tick(); chk("t4b_g2_pressed", pressed, 1'b1);
      tick(); chk("t4b_g3_pressed", pressed, 1'b0);
      chk("t4b_row", row, 4'b1101);
      keys = 16'h0000;

      // ---------------- T5: reset in the middle of DEB on '5' ----------------
      keys = 16'h0020;
      tick(); tick();                            // cnt = 2
      chk("t5_deb_key", key, 1'b0);
      chk("t5_deb_row", row, 4'b1101);
      reset_n = 1'b0;
      keys    = 16'h0000;
      #1;
      chk("t5_async_row",     row,     4'b1110);
      chk("t5_async_value",   value,   4'h0);
      chk("t5_async_key",     key,     1'b0);
      chk("t5_async_pressed", pressed, 1'b0);
      tick(); chk("t5_held_key", key, 1'b0);
      reset_n = 1'b1;
      chk("t5_release_row", row, 4'b1110);
      tick(); chk("t5_first_edge_row", row, 4'b1101);
      chk("t5_first_edge_key", key, 1'b0);
      keys = 16'h0020;                           // fresh debounce after reset
      tick(); tick();
      chk("t5_again_e1_key", key, 1'b0);
      tick(); chk("t5_again_key", key, 1'b1);
      chk("t5_again_value", value, 4'h5);
      keys = 16'h0000;
      tick(); tick(); tick();
      chk("t5_again_rel", pressed, 1'b0);

`ifdef KEY_REPEAT_EN
      // ---------------- T6: auto-repeat on '7', none on 'F' ----------------
      keys  = 16'h0100;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         if (key) found = 1;
      end
      chk("t6_7_accept", found, 1);
      chk("t6_7_value",  value, 4'h7);
      for (int i = 1; i <= 200; i++) begin
         tick();
         chk($sformatf("t6_7_key_c%0d", i), key,
             (i >= 125 && (i - 125) % 25 == 0) ? 1'b1 : 1'b0);
      end
      chk("t6_7_value_end", value, 4'h7);
      keys = 16'h0000;
      tick(); tick(); tick();
      keys  = 16'h4000;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick();
         if (key) found = 1;
      end
      chk("t6_f_accept", found, 1);
      strobes = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (key) strobes++;
      end
      chk("t6_f_no_repeat", strobes, 0);
      keys = 16'h0000;
      tick(); tick(); tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
